// File: rtl/tt_serdes_if.sv
// Console TT serial core bundle: transmit and receive handshakes,
// baud enables and the serial pins.
interface tt_serdes_if;
    logic       tx_clk;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       tx_empty;
    logic       tx_out;
    logic       rx_clk;
    logic       rx_in;
    logic       rx_req;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_ferr;

    modport slave (
        input  tx_clk, tx_req, tx_data,
        input  rx_clk, rx_in, rx_req,
        output tx_ack, tx_empty, tx_out,
        output rx_ack, rx_data, rx_empty, rx_ferr
    );

    modport master (
        output tx_clk, tx_req, tx_data,
        output rx_clk, rx_in, rx_req,
        input  tx_ack, tx_empty, tx_out,
        input  rx_ack, rx_data, rx_empty, rx_ferr
    );
endinterface

// File: rtl/tt_serdes.sv
// 8N1 serial transmitter/receiver for the console TT device,
// driven by 1x (tx) and oversampled (rx) baud enables.
module tt_serdes #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        reset,
    tt_serdes_if.slave  bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e     tx_state_q, tx_state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic       tx_out_q, tx_out_d;
    logic       tx_ack_q, tx_ack_d;
    logic       tx_pend_q, tx_pend_d;
    logic       tx_tail_q, tx_tail_d;
    logic       tx_empty_q, tx_empty_d;

    // The last stop period is spent in IDLE (tail) so a queued
    // character can start right at the end of the stop bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_out_d   = tx_out_q;
        tx_pend_d  = tx_pend_q;
        tx_tail_d  = tx_tail_q;
        tx_ack_d   = tx_ack_q & bus.tx_req;
        unique case (tx_state_q)
            IDLE: begin
                if (bus.tx_clk) begin
                    tx_tail_d = 1'b0;
                end
                if (tx_pend_q) begin
                    if (bus.tx_clk) begin
                        tx_state_d = START;
                        tx_out_d   = 1'b0;
                        tx_pend_d  = 1'b0;
                    end
                end else if (bus.tx_req && !tx_ack_q) begin
                    tx_shift_d = bus.tx_data;
                    tx_pend_d  = 1'b1;
                    tx_ack_d   = 1'b1;
                end
            end
            START: begin
                if (bus.tx_clk) begin
                    tx_state_d = DATA;
                    tx_out_d   = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bus.tx_clk) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_out_d = 1'b1;
                        if (STOP_BITS > 1) begin
                            tx_state_d = STOP;
                        end else begin
                            tx_state_d = IDLE;
                            tx_tail_d  = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_out_d   = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (bus.tx_clk) begin
                    tx_state_d = IDLE;
                    tx_tail_d  = 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
        tx_empty_d = (tx_state_d == IDLE) && !tx_pend_d
                     && !tx_tail_d && !tx_ack_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= IDLE;
            tx_shift_q <= 8'd0;
            tx_bit_q   <= 3'd0;
            tx_out_q   <= 1'b1;
            tx_ack_q   <= 1'b0;
            tx_pend_q  <= 1'b0;
            tx_tail_q  <= 1'b0;
            tx_empty_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_out_q   <= tx_out_d;
            tx_ack_q   <= tx_ack_d;
            tx_pend_q  <= tx_pend_d;
            tx_tail_q  <= tx_tail_d;
            tx_empty_q <= tx_empty_d;
        end
    end

    logic          rx_s1_q, rx_s2_q;
    logic          rx_prev_q, rx_prev_d;
    state_e        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_tick_q, rx_tick_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_hold_q, rx_hold_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_empty_q, rx_empty_d;
    logic          rx_ack_q, rx_ack_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          rx_char_ok;
    logic          rx_ack_fire;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_prev_d  = bus.rx_clk ? rx_s2_q : rx_prev_q;
        rx_ferr_d  = 1'b0;
        rx_char_ok = 1'b0;
        if (bus.rx_clk) begin
            unique case (rx_state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_d = START;
                        rx_tick_d  = '0;
                    end
                end
                START: begin
                    if (rx_tick_q == HALF_M1) begin
                        if (rx_s2_q) begin
                            rx_state_d = IDLE;
                        end else begin
                            rx_state_d = DATA;
                            rx_tick_d  = '0;
                            rx_bit_d   = 3'd0;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + CW'(1);
                    end
                end
                DATA: begin
                    if (rx_tick_q == FULL_M1) begin
                        rx_tick_d  = '0;
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + CW'(1);
                    end
                end
                STOP: begin
                    if (rx_tick_q == FULL_M1) begin
                        rx_state_d = IDLE;
                        rx_char_ok = rx_s2_q;
                        rx_ferr_d  = !rx_s2_q;
                    end else begin
                        rx_tick_d = rx_tick_q + CW'(1);
                    end
                end
                default: rx_state_d = IDLE;
            endcase
        end
    end

    // An ack frees the hold register on the same edge, so a character
    // completing then still lands instead of being dropped.
    always_comb begin
        rx_hold_d   = rx_hold_q;
        rx_data_d   = rx_data_q;
        rx_empty_d  = rx_empty_q;
        rx_ack_fire = bus.rx_req && !rx_empty_q && !rx_ack_q;
        rx_ack_d    = rx_ack_q ? bus.rx_req : rx_ack_fire;
        if (rx_ack_fire) begin
            rx_data_d  = rx_hold_q;
            rx_empty_d = 1'b1;
        end
        if (rx_char_ok && (rx_empty_q || rx_ack_fire)) begin
            rx_hold_d  = rx_shift_q;
            rx_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_hold_q  <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_empty_q <= 1'b1;
            rx_ack_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_s1_q    <= bus.rx_in;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_hold_q  <= rx_hold_d;
            rx_data_q  <= rx_data_d;
            rx_empty_q <= rx_empty_d;
            rx_ack_q   <= rx_ack_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign bus.tx_ack   = tx_ack_q;
    assign bus.tx_empty = tx_empty_q;
    assign bus.tx_out   = tx_out_q;
    assign bus.rx_ack   = rx_ack_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_empty = rx_empty_q;
    assign bus.rx_ferr  = rx_ferr_q;

endmodule

// File: tb/tb_tt_serdes.sv
// Scoreboard bench for tt_serdes: directed tx/rx frames, glitch,
// framing error, overrun, ack/complete collision and mid-frame reset.
module tb_tt_serdes;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tt_serdes_if bus ();

    tt_serdes #(
        .OVERSAMPLE(16),
        .STOP_BITS (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int tx_start_last = 0;
    int tx_start_prev = 0;
    bit tx_abort = 1'b0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 1x enable every 4 clk; receiver oversamples on every clk.
    initial begin
        int div = 0;
        bus.tx_clk = 1'b0;
        bus.rx_clk = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_clk = (div == 3);
            div = (div + 1) % 4;
        end
    end

    initial begin
        logic [7:0] b;
        logic s0, sp;
        forever begin
            @(negedge clk);
            if (bus.tx_out === 1'b0 && reset === 1'b0) begin
                tx_start_prev = tx_start_last;
                tx_start_last = cyc;
                repeat (2) @(negedge clk);
                s0 = bus.tx_out;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = bus.tx_out;
                end
                repeat (4) @(negedge clk);
                sp = bus.tx_out;
                if (tx_abort) begin
                    tx_abort = 1'b0;
                end else begin
                    chk("tx_start_bit", {31'd0, s0}, 0);
                    if (tx_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_frame: got %0h, required none", b);
                    end else begin
                        chk("tx_frame", {24'd0, b}, {24'd0, tx_exp.pop_front()});
                    end
                    chk("tx_stop_bit", {31'd0, sp}, 1);
                end
            end
        end
    end

    initial begin
        logic pa = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rx_ferr === 1'b1) ferr_cnt++;
            if (bus.rx_ack === 1'b1 && !pa) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_data: got %0h, required none", bus.rx_data);
                end else begin
                    chk("rx_data", {24'd0, bus.rx_data}, {24'd0, rx_exp.pop_front()});
                end
            end
            pa = (bus.rx_ack === 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit hit, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic tx_send(input logic [7:0] d, input bit push,
                           output int n, output logic pe);
        pe = bus.tx_empty;
        bus.tx_data = d;
        bus.tx_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.tx_ack !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ack_seen", {31'd0, bus.tx_ack}, 1);
        chk("tx_empty_at_ack", {31'd0, bus.tx_empty}, 0);
        if (push) tx_exp.push_back(d);
        tick(1);
        bus.tx_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("tx_ack_fall", {31'd0, bus.tx_ack}, 0);
        tick(1);
    endtask

    task automatic wait_tx_empty();
        int n = 0;
        @(negedge clk);
        while (bus.tx_empty !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("tx_empty_rise", {31'd0, bus.tx_empty}, 1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx_in = f[i];
            tick(16);
        end
    endtask

    task automatic rx_read(input logic [7:0] d);
        int n = 0;
        rx_exp.push_back(d);
        bus.rx_req = 1'b1;
        @(negedge clk);
        while (bus.rx_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rx_ack_seen", {31'd0, bus.rx_ack}, 1);
        chk("rx_empty_at_ack", {31'd0, bus.rx_empty}, 1);
        tick(1);
        bus.rx_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rx_ack_fall", {31'd0, bus.rx_ack}, 0);
        tick(1);
    endtask

    initial begin
        int n, n2, f0;
        logic pe;
        reset = 1'b1;
        bus.tx_req = 1'b0;
        bus.tx_data = 8'd0;
        bus.rx_in = 1'b1;
        bus.rx_req = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_tx_ack", {31'd0, bus.tx_ack}, 0);
        chk("rst_tx_empty", {31'd0, bus.tx_empty}, 1);
        chk("rst_tx_out", {31'd0, bus.tx_out}, 1);
        chk("rst_rx_ack", {31'd0, bus.rx_ack}, 0);
        chk("rst_rx_data", {24'd0, bus.rx_data}, 0);
        chk("rst_rx_empty", {31'd0, bus.rx_empty}, 1);
        chk("rst_rx_ferr", {31'd0, bus.rx_ferr}, 0);
        tick(1);
        reset = 1'b0;
        tick(5);

        tx_send(8'h41, 1'b1, n, pe);
        chk("tx_empty_before_ack", {31'd0, pe}, 1);
        wait_tx_empty();
        chk("tx_empty_at_stop_end", cyc - tx_start_last, 40);
        tick(1);

        tx_send(8'h55, 1'b1, n, pe);
        tx_send(8'hAA, 1'b1, n2, pe);
        chk("tx_b2b_ack_held_off", {31'd0, (n2 >= 30)}, 1);
        wait_tx_empty();
        chk("tx_b2b_contiguous", tx_start_last - tx_start_prev, 40);
        tick(1);

        send_rx(8'h5A, 1'b1);
        @(negedge clk);
        chk("rx_basic_full", {31'd0, bus.rx_empty}, 0);
        tick(1);
        rx_read(8'h5A);
        bus.rx_req = 1'b1;
        tick(4);
        @(negedge clk);
        chk("rx_req_when_empty", {31'd0, bus.rx_ack}, 0);
        tick(1);
        bus.rx_req = 1'b0;
        tick(2);

        f0 = ferr_cnt;
        bus.rx_in = 1'b0;
        tick(4);
        bus.rx_in = 1'b1;
        tick(40);
        @(negedge clk);
        chk("rx_glitch_empty", {31'd0, bus.rx_empty}, 1);
        chk("rx_glitch_no_ferr", ferr_cnt - f0, 0);
        tick(1);
        send_rx(8'h33, 1'b0);
        bus.rx_in = 1'b1;
        tick(20);
        @(negedge clk);
        chk("rx_ferr_pulses", ferr_cnt - f0, 1);
        chk("rx_ferr_empty", {31'd0, bus.rx_empty}, 1);
        tick(1);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        @(negedge clk);
        chk("rx_overrun_full", {31'd0, bus.rx_empty}, 0);
        tick(1);
        rx_exp.push_back(8'h11);
        fork
            send_rx(8'h33, 1'b1);
            begin
                tick(154);
                bus.rx_req = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("rx_simul_ack", {31'd0, bus.rx_ack}, 1);
                chk("rx_simul_data", {24'd0, bus.rx_data}, 8'h11);
                chk("rx_simul_pending", {31'd0, bus.rx_empty}, 0);
                tick(1);
                bus.rx_req = 1'b0;
            end
        join
        tick(2);
        rx_read(8'h33);

        send_rx(8'h44, 1'b1);
        bus.tx_data = 8'hC3;
        bus.tx_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.tx_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_pre_tx_ack", {31'd0, bus.tx_ack}, 1);
        tick(1);
        bus.tx_req = 1'b0;
        bus.rx_in = 1'b0;
        tick(30);
        tx_abort = 1'b1;
        reset = 1'b1;
        bus.rx_in = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_tx_out", {31'd0, bus.tx_out}, 1);
        chk("midrst_tx_empty", {31'd0, bus.tx_empty}, 1);
        chk("midrst_rx_empty", {31'd0, bus.rx_empty}, 1);
        tick(60);

        fork
            tx_send(8'h7E, 1'b1, n, pe);
            send_rx(8'h7E, 1'b1);
        join
        rx_read(8'h7E);
        wait_tx_empty();
        tick(4);
        chk("tx_queue_drained", tx_exp.size(), 0);
        chk("rx_queue_drained", rx_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_serdes.md
Name: tt_serdes

Overview:
- 8N1 serial transmitter/receiver core for the console TT device; sits directly downstream of the TT IOT logic.
- Consumes the console's four-phase tx_req/tx_ack and rx_req/rx_ack handshakes.
- Drives and samples the serial pins using baud enables from the baud-rate generator.
- All logic runs in the clk domain; tx_clk and rx_clk are single-cycle enables synchronous to clk, not clocks.

Parameters:
- OVERSAMPLE, 16, rx_clk pulses per bit time (even, >=4).
- STOP_BITS, 1, transmitted stop bits (1 or 2); the receiver checks only the first.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high.
- tx_clk in 1: 1x baud enable.
- tx_req in 1: transmit request from the console.
- tx_data in 8: character to send; valid while tx_req=1.
- tx_ack out 1: transmit request accepted.
- tx_empty out 1: no character pending or in flight.
- tx_out out 1: serial output, idle high.
- rx_clk in 1: OVERSAMPLE x baud enable.
- rx_in in 1: asynchronous serial input.
- rx_req in 1: console requests the held character.
- rx_ack out 1: character transferred to rx_data.
- rx_data out 8: last character delivered; held stable until the next ack.
- rx_empty out 1: receive holding register empty.
- rx_ferr out 1: one-clk pulse on a framing error.

Behaviour:
- Reset values: tx_ack=0, tx_empty=1, tx_out=1, rx_ack=0, rx_data=0, rx_empty=1, rx_ferr=0. All counters and FSMs return to IDLE. A reset mid-frame aborts the frame immediately, so tx_out=1 on the next cycle.
- TX handshake:
  - In IDLE with tx_req=1, tx_data is latched into the shift register on that edge.
  - tx_ack=1 and tx_empty=0 both take effect on the same edge.
  - tx_ack stays 1 while tx_req=1 and falls on the first edge after tx_req=0.
  - tx_req is ignored while tx_ack=1 or while the FSM is not IDLE.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - State advances only on tx_clk pulses.
  - The first tx_clk after load enters START: tx_out=0 for one tx_clk period.
  - DATA sends 8 bits LSB first, one per period, tracked by a 3-bit counter.
  - STOP holds tx_out=1 for STOP_BITS periods.
  - At the end of STOP the FSM returns to IDLE and tx_empty=1 on that edge.
  - tx_empty never rises while tx_ack=1.
- RX input conditioning: rx_in passes through a 2-flop synchronizer, giving 2 clk of latency before detection.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, sampling on rx_clk pulses.
  - IDLE: a 1->0 transition of the synchronized input resets the tick counter and enters START.
  - START: at tick OVERSAMPLE/2 the line is resampled. If it is 1 (glitch), return to IDLE with no output. If 0, zero the counter.
  - DATA: each bit is sampled every OVERSAMPLE ticks thereafter, at bit centre, and shifted in LSB first.
  - STOP: sampled one bit time after the last data bit. If 1, the character is valid. If 0, pulse rx_ferr for one clk and discard the character.
  - After sampling the stop bit the FSM returns to IDLE immediately and can detect the next start edge without waiting a full stop period.
- RX holding register:
  - A valid character is written to the hold register and rx_empty=0 is set.
  - If the hold register is already full (rx_empty=0), the new character is discarded; the hold register is unchanged and no error is flagged.
- RX handshake:
  - With rx_req=1, rx_empty=0 and rx_ack=0, on the next edge: rx_data <= hold, rx_ack=1, rx_empty=1.
  - rx_ack stays 1 while rx_req=1 and falls on the first edge after rx_req=0.
  - rx_req while rx_empty=1 is ignored; there is no ack.
  - rx_data changes only on an ack edge.
  - A character completing on the same edge as an ack is written to the now-freed hold register, so rx_empty stays 0.
- The TX and RX paths are fully independent; simultaneous activity on both has no interaction.

Test Plan:
- TX basic: tx_clk every 4 clk; tx_req=1 with tx_data=0x41 until tx_ack, then drop.
  -> tx_ack and tx_empty=0 on the same edge.
  -> tx_out sequence 0,1,0,0,0,0,0,1,0,1, each lasting 4 clk.
  -> tx_empty=1 at the end of the stop bit.
- TX back-to-back: request 0x55 then 0xAA, with the second tx_req raised while the first is busy.
  -> no ack until IDLE.
  -> frames are contiguous with exactly 1 stop bit between them.
- RX basic: rx_clk every clk, OVERSAMPLE=16; drive a 0x5A frame at 16 clk per bit.
  -> rx_empty=0.
  -> rx_req gives rx_ack, rx_data=0x5A, rx_empty=1.
  -> rx_ack falls one edge after rx_req drops.
- RX glitch and framing: a 4-clk low pulse on rx_in -> no character. A 0x33 frame with stop=0 -> one rx_ferr pulse and rx_empty stays 1.
- RX overrun and simultaneity:
  -> receive 0x11 without requesting it, then 0x22 -> hold retains 0x11.
  -> ack 0x11 on the same edge that 0x33 completes -> rx_data=0x11, then 0x33 pending with rx_empty=0.
- Reset mid-frame: assert reset during TX DATA and RX DATA.
  -> tx_out=1, tx_empty=1, rx_empty=1 next cycle.
  -> a subsequent 0x7E frame is sent and received correctly.
